// File: rtl/noc_axi_wr_master_if.sv
// AXI write-channel bundle (AW, W, B) between the NoC write master and the crossbar port.
interface noc_axi_wr_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] m_awaddr;
  logic              m_awvalid;
  logic              m_awready;
  logic [DATA_W-1:0] m_wdata;
  logic              m_wvalid;
  logic              m_wready;
  logic [1:0]        m_bresp;
  logic              m_bvalid;
  logic              m_bready;

  modport master (
    output m_awaddr, m_awvalid, m_wdata, m_wvalid, m_bready,
    input  m_awready, m_wready, m_bresp, m_bvalid
  );

  modport slave (
    input  m_awaddr, m_awvalid, m_wdata, m_wvalid, m_bready,
    output m_awready, m_wready, m_bresp, m_bvalid
  );
endinterface

// File: rtl/noc_axi_wr_master.sv
// Write-issue stage: buffers client address/data requests and issues each as a single
// AXI write (AW + W + B), one outstanding, with a response timeout that latches a fault.
module noc_axi_wr_master #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_data,
  noc_axi_wr_master_if.master           axi,
  output logic                          done,
  output logic                          err,
  output logic                          fault,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_B, FAULT} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [LVL_W-1:0]  level_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              push;
  logic              pop;
  logic              aw_pending;
  logic              w_pending;

  assign req_ready  = (level_reg != FULL_LVL);
  assign push       = req_valid & req_ready;
  assign pop        = (state_reg == IDLE) && (level_reg != '0);
  assign fifo_level = level_reg;
  assign busy       = (state_reg != IDLE) || (level_reg != '0);

  // A channel is still pending if its valid is up and no ready is seen this cycle.
  assign aw_pending = axi.m_awvalid & ~axi.m_awready;
  assign w_pending  = axi.m_wvalid & ~axi.m_wready;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= req_addr;
      data_mem[wr_ptr_reg] <= req_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      axi.m_awaddr  <= '0;
      axi.m_wdata   <= '0;
      axi.m_awvalid <= 1'b0;
      axi.m_wvalid  <= 1'b0;
      axi.m_bready  <= 1'b0;
      cnt_reg       <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      fault         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pop) begin
            axi.m_awaddr  <= addr_mem[rd_ptr_reg];
            axi.m_wdata   <= data_mem[rd_ptr_reg];
            axi.m_awvalid <= 1'b1;
            axi.m_wvalid  <= 1'b1;
            state_reg     <= SEND;
          end
        end
        SEND: begin
          if (axi.m_awready) axi.m_awvalid <= 1'b0;
          if (axi.m_wready)  axi.m_wvalid  <= 1'b0;
          if (!aw_pending && !w_pending) begin
            axi.m_bready <= 1'b1;
            cnt_reg      <= '0;
            state_reg    <= WAIT_B;
          end
        end
        WAIT_B: begin
          // A response in the same cycle the counter expires takes priority over the timeout.
          if (axi.m_bvalid) begin
            axi.m_bready <= 1'b0;
            done         <= (axi.m_bresp == 2'b00);
            err          <= (axi.m_bresp != 2'b00);
            state_reg    <= IDLE;
          end else if (cnt_reg == CNT_LAST) begin
            err       <= 1'b1;
            fault     <= 1'b1;
            state_reg <= FAULT;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        FAULT: begin
          axi.m_bready <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_noc_axi_wr_master.sv
// Directed bench for noc_axi_wr_master: latency, channel skew, FIFO full, error response,
// timeout boundary, timeout fault and reset behaviour.
module tb_noc_axi_wr_master;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        done, err, fault, busy;
  logic [2:0]  fifo_level;
  int          total = 0;
  int          bad = 0;

  noc_axi_wr_master_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  noc_axi_wr_master #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .axi(axi),
    .done(done), .err(err), .fault(fault), .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (done || err)
      $display("txn addr=%h data=%h done=%0b err=%0b fault=%0b",
               axi.m_awaddr, axi.m_wdata, done, err, fault);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if ({axi.m_awvalid, axi.m_wvalid, axi.m_bready, done, err, fault, busy} !== 7'b0) begin
      $display("FAIL reset_ctrl got=%b want=0000000",
               {axi.m_awvalid, axi.m_wvalid, axi.m_bready, done, err, fault, busy});
      bad++;
    end
    total++;
    if (fifo_level !== 3'd0 || req_ready !== 1'b1) begin
      $display("FAIL reset_fifo level=%0d ready=%b want level=0 ready=1", fifo_level, req_ready);
      bad++;
    end
    total++;
    if (axi.m_awaddr !== 32'h0 || axi.m_wdata !== 32'h0) begin
      $display("FAIL reset_bus awaddr=%h wdata=%h want 0", axi.m_awaddr, axi.m_wdata);
      bad++;
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    axi.m_awready = 1'b1;
    axi.m_wready  = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h1000_0040;
    req_data  = 32'hDEAD_BEEF;
    tick();
    req_valid = 1'b0;
    total++;
    if (axi.m_awvalid !== 1'b0 || fifo_level !== 3'd1 || busy !== 1'b1) begin
      $display("FAIL single_accept awvalid=%b level=%0d busy=%b want 0/1/1", axi.m_awvalid, fifo_level, busy);
      bad++;
    end
    tick();
    total++;
    if ({axi.m_awvalid, axi.m_wvalid} !== 2'b11 || axi.m_awaddr !== 32'h1000_0040 ||
        axi.m_wdata !== 32'hDEAD_BEEF || fifo_level !== 3'd0) begin
      $display("FAIL single_issue valids=%b addr=%h data=%h level=%0d want 11/10000040/deadbeef/0",
               {axi.m_awvalid, axi.m_wvalid}, axi.m_awaddr, axi.m_wdata, fifo_level);
      bad++;
    end
    tick();
    total++;
    if ({axi.m_awvalid, axi.m_wvalid, axi.m_bready} !== 3'b001) begin
      $display("FAIL single_waitb got=%b want=001", {axi.m_awvalid, axi.m_wvalid, axi.m_bready});
      bad++;
    end
    axi.m_bvalid = 1'b1;
    axi.m_bresp  = 2'b00;
    tick();
    axi.m_bvalid = 1'b0;
    total++;
    if ({done, err, axi.m_bready, busy} !== 4'b1000) begin
      $display("FAIL single_done got=%b want=1000", {done, err, axi.m_bready, busy});
      bad++;
    end
    tick();
    total++;
    if (done !== 1'b0) begin
      $display("FAIL single_pulse done=%b want=0", done);
      bad++;
    end
  endtask

  task automatic test_skew();
    int moved = 0;
    axi.m_awready = 1'b0;
    axi.m_wready  = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h2000_0000;
    req_data  = 32'h1111_2222;
    tick();
    req_valid = 1'b0;
    tick();
    axi.m_awready = 1'b1;
    tick();
    axi.m_awready = 1'b0;
    total++;
    if ({axi.m_awvalid, axi.m_wvalid, axi.m_bready} !== 3'b010) begin
      $display("FAIL skew_aw_drop got=%b want=010", {axi.m_awvalid, axi.m_wvalid, axi.m_bready});
      bad++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (axi.m_wvalid !== 1'b1 || axi.m_wdata !== 32'h1111_2222 || axi.m_bready !== 1'b0) moved++;
    end
    total++;
    if (moved !== 0) begin
      $display("FAIL skew_w_hold unstable_cycles=%0d want=0", moved);
      bad++;
    end
    axi.m_wready = 1'b1;
    tick();
    axi.m_wready = 1'b0;
    total++;
    if ({axi.m_wvalid, axi.m_bready} !== 2'b01) begin
      $display("FAIL skew_w_done got=%b want=01", {axi.m_wvalid, axi.m_bready});
      bad++;
    end
    axi.m_bvalid = 1'b1;
    tick();
    axi.m_bvalid = 1'b0;
    total++;
    if (done !== 1'b1) begin
      $display("FAIL skew_resp done=%b want=1", done);
      bad++;
    end
    tick();
  endtask

  task automatic test_error_resp();
    axi.m_awready = 1'b1;
    axi.m_wready  = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h4000_0000;
    req_data  = 32'hE0E0_E0E0;
    tick();
    req_addr  = 32'h4000_0004;
    req_data  = 32'hE1E1_E1E1;
    tick();
    req_valid = 1'b0;
    tick();
    axi.m_bvalid = 1'b1;
    axi.m_bresp  = 2'b10;
    tick();
    axi.m_bvalid = 1'b0;
    axi.m_bresp  = 2'b00;
    total++;
    if ({err, done} !== 2'b10) begin
      $display("FAIL err_pulse err_done=%b want=10", {err, done});
      bad++;
    end
    tick();
    total++;
    if (err !== 1'b0 || axi.m_awvalid !== 1'b1 || axi.m_awaddr !== 32'h4000_0004) begin
      $display("FAIL err_next err=%b awvalid=%b addr=%h want 0/1/40000004", err, axi.m_awvalid, axi.m_awaddr);
      bad++;
    end
    tick();
    axi.m_bvalid = 1'b1;
    tick();
    axi.m_bvalid = 1'b0;
    total++;
    if (done !== 1'b1) begin
      $display("FAIL err_second_done done=%b want=1", done);
      bad++;
    end
    tick();
  endtask

  task automatic test_fifo_full();
    logic [31:0] fa [6];
    int idx = 1;
    int dones = 0;
    for (int i = 0; i < 6; i++) fa[i] = 32'h3000_0000 + 32'(i * 16);
    axi.m_awready = 1'b0;
    axi.m_wready  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_addr  = fa[i];
      req_data  = ~fa[i];
      tick();
    end
    total++;
    if (fifo_level !== 3'd4 || req_ready !== 1'b0) begin
      $display("FAIL full_level level=%0d ready=%b want 4/0", fifo_level, req_ready);
      bad++;
    end
    req_addr = fa[5];
    req_data = ~fa[5];
    tick();
    req_valid = 1'b0;
    total++;
    if (fifo_level !== 3'd4 || axi.m_awaddr !== fa[0] || axi.m_awvalid !== 1'b1) begin
      $display("FAIL full_ignore level=%0d addr=%h awvalid=%b want 4/%h/1", fifo_level, axi.m_awaddr, axi.m_awvalid, fa[0]);
      bad++;
    end
    axi.m_awready = 1'b1;
    axi.m_wready  = 1'b1;
    axi.m_bvalid  = 1'b1;
    axi.m_bresp   = 2'b00;
    for (int c = 0; c < 60 && dones < 5; c++) begin
      tick();
      if (done) dones++;
      if (axi.m_awvalid) begin
        if (idx < 5) begin
          total++;
          if (axi.m_awaddr !== fa[idx] || axi.m_wdata !== ~fa[idx]) begin
            $display("FAIL full_order%0d addr=%h data=%h want %h/%h", idx, axi.m_awaddr, axi.m_wdata, fa[idx], ~fa[idx]);
            bad++;
          end
        end
        idx++;
      end
    end
    axi.m_bvalid  = 1'b0;
    axi.m_awready = 1'b0;
    axi.m_wready  = 1'b0;
    tick();
    total++;
    if (dones !== 5 || idx !== 5 || busy !== 1'b0 || fifo_level !== 3'd0) begin
      $display("FAIL full_drain dones=%0d issued=%0d busy=%b level=%0d want 5/5/0/0", dones, idx, busy, fifo_level);
      bad++;
    end
  endtask

  task automatic test_timeout_race();
    axi.m_awready = 1'b1;
    axi.m_wready  = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h5000_0000;
    req_data  = 32'h5555_5555;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    repeat (7) tick();
    total++;
    if (fault !== 1'b0 || err !== 1'b0 || axi.m_bready !== 1'b1) begin
      $display("FAIL race_pre fault=%b err=%b bready=%b want 0/0/1", fault, err, axi.m_bready);
      bad++;
    end
    axi.m_bvalid = 1'b1;
    tick();
    axi.m_bvalid = 1'b0;
    total++;
    if ({done, err, fault} !== 3'b100) begin
      $display("FAIL race_bvalid_wins done_err_fault=%b want=100", {done, err, fault});
      bad++;
    end
    tick();
  endtask

  task automatic test_reset_mid_send();
    axi.m_awready = 1'b0;
    axi.m_wready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'h6000_0000 + 32'(i * 4);
      req_data  = 32'h6600_0000 + 32'(i);
      tick();
    end
    req_valid = 1'b0;
    total++;
    if (axi.m_awvalid !== 1'b1 || fifo_level !== 3'd2) begin
      $display("FAIL rst_send_pre awvalid=%b level=%0d want 1/2", axi.m_awvalid, fifo_level);
      bad++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({axi.m_awvalid, axi.m_wvalid, axi.m_bready} !== 3'b000 || fifo_level !== 3'd0 || req_ready !== 1'b1) begin
      $display("FAIL rst_send_post valids=%b level=%0d ready=%b want 000/0/1",
               {axi.m_awvalid, axi.m_wvalid, axi.m_bready}, fifo_level, req_ready);
      bad++;
    end
    tick();
    total++;
    if (axi.m_awvalid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL rst_send_replay awvalid=%b busy=%b want 0/0", axi.m_awvalid, busy);
      bad++;
    end
  endtask

  task automatic test_timeout();
    int early = 0;
    int late = 0;
    axi.m_awready = 1'b1;
    axi.m_wready  = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h7000_0000;
    req_data  = 32'h7777_0000;
    tick();
    req_addr  = 32'h7000_0004;
    req_data  = 32'h7777_0001;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      if (err || fault) early++;
    end
    total++;
    if (early !== 0) begin
      $display("FAIL to_early flagged_cycles=%0d want=0", early);
      bad++;
    end
    tick();
    total++;
    if ({err, fault, done, axi.m_bready} !== 4'b1101) begin
      $display("FAIL to_trip err_fault_done_bready=%b want=1101", {err, fault, done, axi.m_bready});
      bad++;
    end
    tick();
    total++;
    if ({err, fault, axi.m_bready} !== 3'b011) begin
      $display("FAIL to_sticky err_fault_bready=%b want=011", {err, fault, axi.m_bready});
      bad++;
    end
    axi.m_bvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done || err || axi.m_awvalid || axi.m_bready !== 1'b1) late++;
    end
    axi.m_bvalid = 1'b0;
    total++;
    if (late !== 0 || fifo_level !== 3'd1) begin
      $display("FAIL to_hold bad_cycles=%0d level=%0d want 0/1", late, fifo_level);
      bad++;
    end
    req_valid = 1'b1;
    req_addr  = 32'h7000_0008;
    tick();
    req_valid = 1'b0;
    total++;
    if (fifo_level !== 3'd2 || axi.m_awvalid !== 1'b0) begin
      $display("FAIL to_push level=%0d awvalid=%b want 2/0", fifo_level, axi.m_awvalid);
      bad++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (fault !== 1'b0 || fifo_level !== 3'd0 || axi.m_bready !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL to_reset fault=%b level=%0d bready=%b busy=%b want 0/0/0/0", fault, fifo_level, axi.m_bready, busy);
      bad++;
    end
  endtask

  initial begin
    axi.m_awready = 1'b0;
    axi.m_wready  = 1'b0;
    axi.m_bvalid  = 1'b0;
    axi.m_bresp   = 2'b00;
    test_reset();
    test_single();
    test_skew();
    test_error_resp();
    test_fifo_full();
    test_timeout_race();
    test_reset_mid_send();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/noc_axi_wr_master.md
Name: noc_axi_wr_master

Overview:
- Master-side write-issue stage directly upstream of the AXI NoC crossbar.
- Accepts simple address/data write requests from a dashcam client (DMA, ISP writeback) and buffers them in a small FIFO.
- Converts each request into one AXI write transaction (AW + W + B) on a NoC master port.
- One transaction outstanding at a time. Tracks the response and reports done/error.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- FIFO_DEPTH, 4, request FIFO entries; must be a power of 2 and ≥2.
- TIMEOUT, 255, maximum cycles spent in WAIT_B before a timeout fault; must be ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  client request valid.
- req_ready  out  1  FIFO can accept a request (not full).
- req_addr  in  ADDR_W  write address.
- req_data  in  DATA_W  write data.
- m_awaddr  out  ADDR_W  AXI write address.
- m_awvalid  out  1  AW valid.
- m_awready  in  1  AW ready.
- m_wdata  out  DATA_W  AXI write data.
- m_wvalid  out  1  W valid.
- m_wready  in  1  W ready.
- m_bresp  in  2  write response code.
- m_bvalid  in  1  B valid.
- m_bready  out  1  B ready.
- done  out  1  one-cycle pulse: response OKAY.
- err  out  1  one-cycle pulse: response non-OKAY, or timeout.
- fault  out  1  sticky: a timeout has occurred.
- busy  out  1  FSM not IDLE, or FIFO not empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (clk edge with reset=1):
  - FIFO emptied; fifo_level=0; req_ready=1.
  - FSM goes to IDLE.
  - m_awvalid, m_wvalid, m_bready, done, err, fault, busy all 0.
  - m_awaddr and m_wdata driven to 0.
  - Timeout counter cleared.
  - Reset mid-transaction abandons it; nothing is replayed.
- FIFO:
  - Push when req_valid & req_ready; req_ready = (fifo_level != FIFO_DEPTH).
  - Pop occurs only in IDLE when not empty.
  - Simultaneous push and pop: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - A push while full is ignored (req_ready=0).
- FSM states: IDLE, SEND, WAIT_B, FAULT.
  - IDLE:
    - If FIFO not empty: pop, register addr/data into m_awaddr/m_wdata.
    - Set m_awvalid=m_wvalid=1; go to SEND.
    - Latency: request accepted on edge k into an empty FIFO with the FSM idle → valids high after edge k+1.
  - SEND:
    - AW and W are independent. Each valid drops on the edge where its own ready is seen.
    - Address and data stay stable while the corresponding valid is high.
    - When both handshakes have completed (same cycle or different cycles): go to WAIT_B, set m_bready=1, clear the timeout counter.
    - No timeout applies in SEND.
  - WAIT_B:
    - On m_bvalid & m_bready: m_bready=0, go to IDLE.
    - Pulse done if m_bresp==2'b00; pulse err otherwise (SLVERR or DECERR).
    - Counter increments each cycle without bvalid. When it reaches TIMEOUT: err pulse, fault=1, go to FAULT.
    - A bvalid arriving in the cycle the counter hits TIMEOUT wins; no fault is raised.
  - FAULT:
    - m_bready held at 1 to swallow late responses; no done/err pulses.
    - No further pops. FIFO still accepts pushes until full.
    - Exit only by reset.
- In IDLE the next pop can occur on the edge after the B handshake. Back-to-back throughput is one transaction per 3 cycles minimum with zero-wait slaves.
- busy = (state != IDLE) | (fifo_level != 0).
- done and err are registered and never high together.

Test Plan:
- Single write: push addr=0x1000_0040, data=0xDEAD_BEEF with ready tied high and bvalid one cycle after AW/W → AW/W valid 2 edges after accept, carrying those values; done pulses once; busy returns to 0.
- AW/W skew: m_awready high at cycle 2, m_wready delayed until cycle 6 → m_awvalid drops after cycle 2, m_wvalid stays high with data stable until cycle 6; m_bready rises only after cycle 6.
- FIFO full: hold m_awready=0 and push 5 requests with FIFO_DEPTH=4 → 1 request in flight plus 4 queued; req_ready=0 on the 6th; all 5 issue in order once ready is released.
- Error response: m_bresp=2'b10 → err pulses one cycle, done stays 0, FSM returns to IDLE and issues the next request.
- Timeout: TIMEOUT=8, never assert m_bvalid → err and fault rise on the 8th WAIT_B cycle; m_bready stays 1; the queued request is never issued; reset clears fault and the FIFO.
- Reset mid-SEND: assert reset while m_awvalid=1 → next cycle all valids are 0, fifo_level=0, req_ready=1.
